// File: rtl/imem_load_ctrl_pkg.sv
// Shared definitions for the instruction-memory boot sequencer:
// state encoding, error codes and the default fill byte.
package imem_load_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_FILL = 3'd2,
        ST_BOOT = 3'd3,
        ST_RUN  = 3'd4,
        ST_DONE = 3'd5
    } ldc_state_e;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_BAD_LEN = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;
    localparam logic [1:0] ERR_ABORTED = 2'd3;

    // The unused tail of the program image is padded with NOPs.
    localparam logic [7:0] NOP_OPCODE   = 8'h00;
    localparam logic [7:0] FILL_DEFAULT = NOP_OPCODE;

endpackage

// File: rtl/imem_load_ctrl_watchdog.sv
// RUN-phase watchdog: counts enabled cycles from a clear and flags the
// cycle on which the LIMIT-th enabled cycle is being spent.
module ldc_watchdog #(
    parameter int unsigned LIMIT = 1024
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CW = $clog2(LIMIT + 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    // count holds the number of RUN cycles already completed, so the
    // current cycle is the last allowed one when it equals LIMIT-1.
    assign expired = enable && (count == CW'(LIMIT - 1));

endmodule

// File: rtl/imem_load_ctrl.sv
// Boot sequencer: streams a program into instruction memory, NOP-fills the
// tail, pulses CPU reset, then supervises the run until halt or timeout.
module imem_load_ctrl
    import imem_load_ctrl_pkg::*;
#(
    parameter int unsigned       DATA_W      = 8,
    parameter int unsigned       ADDR_W      = 8,
    parameter int unsigned       DEPTH       = 256,
    parameter logic [DATA_W-1:0] FILL_VALUE  = DATA_W'(FILL_DEFAULT),
    parameter int unsigned       WDOG_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W:0]   load_len,
    input  logic              abort,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              imem_we,
    output logic              imem_re,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [DATA_W-1:0] imem_wdata,
    output logic              cpu_reset,
    input  logic              halt_det,
    output logic              busy,
    output logic              done,
    output logic [1:0]        err_code,
    output logic [2:0]        state_o
);

    localparam logic [ADDR_W:0]   DEPTH_L   = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    ldc_state_e        state, state_n;
    logic [ADDR_W-1:0] addr, addr_n;
    logic [ADDR_W:0]   len_q, len_n;
    logic [1:0]        err_n;
    logic              wd_clear, wd_run, wd_expired;
    logic              len_ok, last_byte;

    assign len_ok    = (load_len != '0) && (load_len <= DEPTH_L);
    assign last_byte = ({1'b0, addr} == (len_q - 1'b1));

    ldc_watchdog #(
        .LIMIT (WDOG_CYCLES)
    ) u_watchdog (
        .clk     (clk),
        .reset   (reset),
        .clear   (wd_clear),
        .enable  (wd_run),
        .expired (wd_expired)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            addr     <= '0;
            len_q    <= '0;
            err_code <= ERR_NONE;
            done     <= 1'b0;
        end else begin
            state    <= state_n;
            addr     <= addr_n;
            len_q    <= len_n;
            err_code <= err_n;
            done     <= (state_n == ST_DONE) && (state != ST_DONE);
        end
    end

    // Byte stream: a byte transfers on a rising clk edge when in_valid and
    // in_ready are both high; in_ready is high only in LOAD without abort,
    // and the write to imem happens in that same cycle.
    always_comb begin
        state_n    = state;
        addr_n     = addr;
        len_n      = len_q;
        err_n      = err_code;
        in_ready   = 1'b0;
        imem_we    = 1'b0;
        imem_re    = 1'b0;
        imem_addr  = '0;
        imem_wdata = '0;
        wd_clear   = 1'b0;
        wd_run     = 1'b0;
        if (abort && (state != ST_IDLE)) begin
            state_n = ST_IDLE;
            err_n   = ERR_ABORTED;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        if (len_ok) begin
                            len_n   = load_len;
                            addr_n  = '0;
                            err_n   = ERR_NONE;
                            state_n = ST_LOAD;
                        end else begin
                            err_n = ERR_BAD_LEN;
                        end
                    end
                end
                ST_LOAD: begin
                    in_ready = 1'b1;
                    if (in_valid) begin
                        imem_we    = 1'b1;
                        imem_addr  = addr;
                        imem_wdata = in_data;
                        // Saturate so a full-depth image leaves addr at the top.
                        if (addr != LAST_ADDR) begin
                            addr_n = addr + 1'b1;
                        end
                        if (last_byte) begin
                            state_n = (len_q == DEPTH_L) ? ST_BOOT : ST_FILL;
                        end
                    end
                end
                ST_FILL: begin
                    imem_we    = 1'b1;
                    imem_addr  = addr;
                    imem_wdata = FILL_VALUE;
                    if (addr == LAST_ADDR) begin
                        state_n = ST_BOOT;
                    end else begin
                        addr_n = addr + 1'b1;
                    end
                end
                ST_BOOT: begin
                    wd_clear = 1'b1;
                    state_n  = ST_RUN;
                end
                ST_RUN: begin
                    imem_re = 1'b1;
                    wd_run  = 1'b1;
                    if (halt_det) begin
                        state_n = ST_DONE;
                        err_n   = ERR_NONE;
                    end else if (wd_expired) begin
                        state_n = ST_DONE;
                        err_n   = ERR_TIMEOUT;
                    end
                end
                default: state_n = ST_IDLE;
            endcase
        end
    end

    assign cpu_reset = (state != ST_RUN);
    assign busy      = (state != ST_IDLE) && (state != ST_DONE);
    assign state_o   = state;

endmodule

// File: tb/tb_imem_load_ctrl.sv
// Self-checking bench for imem_load_ctrl: randomized program loads checked
// against an expected memory image and run-length model.
`timescale 1ns/1ps
module tb_imem_load_ctrl;

    localparam int DW    = 8;
    localparam int AW    = 8;
    localparam int DEPTH = 256;
    localparam int WDOG  = 8;
    localparam logic [DW-1:0] FILL = 8'h00;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LOAD = 3'd1;
    localparam logic [2:0] S_FILL = 3'd2;
    localparam logic [2:0] S_BOOT = 3'd3;
    localparam logic [2:0] S_RUN  = 3'd4;
    localparam logic [2:0] S_DONE = 3'd5;

    // {state,in_ready,we,re,addr,wdata,cpu_reset,busy,done,err}
    localparam logic [26:0] RESET_VEC = {3'd0, 3'b000, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 2'd0};

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [AW:0]   load_len = '0;
    logic          abort = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          halt_det = 1'b0;
    logic          in_ready, imem_we, imem_re, cpu_reset, busy, done;
    logic [AW-1:0] imem_addr;
    logic [DW-1:0] imem_wdata;
    logic [1:0]    err_code;
    logic [2:0]    state_o;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0]   exp_q[$];
    logic [15:0]   obs_q[$];
    logic [DW-1:0] prog [DEPTH];
    int            st_cnt [8];
    int            both_cnt = 0;

    imem_load_ctrl #(
        .DATA_W      (DW),
        .ADDR_W      (AW),
        .DEPTH       (DEPTH),
        .FILL_VALUE  (FILL),
        .WDOG_CYCLES (WDOG)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .load_len   (load_len),
        .abort      (abort),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .imem_we    (imem_we),
        .imem_re    (imem_re),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_reset  (cpu_reset),
        .halt_det   (halt_det),
        .busy       (busy),
        .done       (done),
        .err_code   (err_code),
        .state_o    (state_o)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "global timeout");
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (!reset) begin
            if (imem_we) obs_q.push_back({imem_addr, imem_wdata});
            if (imem_we && imem_re) both_cnt++;
            st_cnt[state_o]++;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_counts();
        for (int i = 0; i < 8; i++) st_cnt[i] = 0;
        obs_q.delete();
    endtask

    // Reference image: program bytes first, the fill byte everywhere else.
    task automatic build_expected(input int len);
        exp_q.delete();
        for (int i = 0; i < DEPTH; i++)
            exp_q.push_back({8'(i), (i < len) ? prog[i] : FILL});
    endtask

    function automatic int image_errors();
        int e = 0;
        for (int i = 0; i < exp_q.size(); i++)
            if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) e++;
        return e;
    endfunction

    function automatic int exp_run_len(input int halt_cyc);
        return (halt_cyc >= 1 && halt_cyc <= WDOG) ? halt_cyc : WDOG;
    endfunction

    function automatic logic [1:0] exp_run_err(input int halt_cyc);
        return (halt_cyc >= 1 && halt_cyc <= WDOG) ? 2'd0 : 2'd2;
    endfunction

    // mode: 0 valid held, 1 valid toggling 1/0, 2 random valid.
    // poke issues stray starts during LOAD and FILL, which must be ignored.
    task automatic do_load(input int len, input int mode, input bit poke,
                           output logic [2:0] st_load, output logic [1:0] err_load,
                           output int load_cyc, output logic [2:0] st_end);
        int  idx;
        int  guard;
        bit  hs;
        clear_counts();
        build_expected(len);
        start = 1'b1;
        load_len = (AW + 1)'(len);
        step();
        start = 1'b0;
        st_load = state_o;
        err_load = err_code;
        idx = 0;
        guard = 0;
        while (idx < len && guard < 4 * DEPTH) begin
            case (mode)
                0:       in_valid = 1'b1;
                1:       in_valid = (guard % 2 == 0);
                default: in_valid = 1'($urandom_range(0, 1));
            endcase
            in_data  = prog[idx];
            start    = poke && (guard == 1);
            load_len = 9'd2;
            @(negedge clk);
            hs = in_valid && in_ready;
            step();
            if (hs) idx++;
            guard++;
        end
        load_cyc = guard;
        start = 1'b0;
        in_valid = 1'b0;
        in_data = 8'($urandom);
        guard = 0;
        while (state_o != S_BOOT && guard < 2 * DEPTH) begin
            start = poke && (guard == 3);
            step();
            guard++;
        end
        start = 1'b0;
        step();
        st_end = state_o;
    endtask

    task automatic run_to_done(input int halt_cyc, output int run_cyc, output int run_bad);
        int guard = 0;
        run_cyc = 0;
        run_bad = 0;
        while (state_o == S_RUN && guard < WDOG + 20) begin
            run_cyc++;
            halt_det = (run_cyc == halt_cyc);
            #1;
            if (cpu_reset !== 1'b0 || imem_re !== 1'b1 || imem_we !== 1'b0) run_bad++;
            step();
            guard++;
        end
        halt_det = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [26:0] v;
        reset = 1'b1;
        in_valid = 1'b1;
        in_data = 8'h5A;
        #3;
        v = {state_o, in_ready, imem_we, imem_re, imem_addr, imem_wdata, cpu_reset, busy, done, err_code};
        n_checks++;
        if (v !== RESET_VEC) begin
            n_fail++;
            $display("FAIL reset_values: got %h expected %h", v, RESET_VEC);
        end
        step();
        reset = 1'b0;
        in_valid = 1'b0;
        step();
        n_checks++;
        if (state_o !== S_IDLE || busy !== 1'b0 || cpu_reset !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release: got state %0d busy %b cpu_reset %b expected 0 0 1",
                     state_o, busy, cpu_reset);
        end
    endtask

    task automatic test_bad_len();
        int lens [3];
        lens[0] = 0;
        lens[1] = DEPTH + 1;
        lens[2] = $urandom_range(DEPTH + 2, 2 * DEPTH - 1);
        foreach (lens[k]) begin
            clear_counts();
            start = 1'b1;
            load_len = (AW + 1)'(lens[k]);
            step();
            start = 1'b0;
            step();
            step();
            n_checks++;
            if (state_o !== S_IDLE || err_code !== 2'd1 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL bad_len_%0d: got state %0d err %0d busy %b expected 0 1 0",
                         lens[k], state_o, err_code, busy);
            end
            n_checks++;
            if (obs_q.size() !== 0) begin
                n_fail++;
                $display("FAIL bad_len_writes_%0d: got %0d expected 0", lens[k], obs_q.size());
            end
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
        n_checks++;
        if (state_o !== S_IDLE || err_code !== 2'd1) begin
            n_fail++;
            $display("FAIL abort_in_idle: got state %0d err %0d expected 0 1", state_o, err_code);
        end
    endtask

    task automatic test_short_load();
        logic [2:0] st_load, st_end;
        logic [1:0] err_load;
        int         load_cyc, run_cyc, run_bad;
        prog[0] = 8'h11; prog[1] = 8'h22; prog[2] = 8'h33; prog[3] = 8'h44;
        do_load(4, 0, 1'b0, st_load, err_load, load_cyc, st_end);
        n_checks++;
        if (st_load !== S_LOAD || err_load !== 2'd0) begin
            n_fail++;
            $display("FAIL short_start: got state %0d err %0d expected 1 0", st_load, err_load);
        end
        n_checks++;
        if (load_cyc !== 4) begin
            n_fail++;
            $display("FAIL short_load_cycles: got %0d expected 4", load_cyc);
        end
        n_checks++;
        if (obs_q.size() !== DEPTH || image_errors() !== 0) begin
            n_fail++;
            $display("FAIL short_image: got %0d writes %0d bad expected %0d writes 0 bad",
                     obs_q.size(), image_errors(), DEPTH);
        end
        n_checks++;
        if (st_cnt[S_FILL] !== DEPTH - 4 || st_cnt[S_BOOT] !== 1 || st_end !== S_RUN) begin
            n_fail++;
            $display("FAIL short_fill_boot: got fill %0d boot %0d state %0d expected %0d 1 4",
                     st_cnt[S_FILL], st_cnt[S_BOOT], st_end, DEPTH - 4);
        end
        run_to_done(0, run_cyc, run_bad);
        n_checks++;
        if (run_cyc !== WDOG || run_bad !== 0) begin
            n_fail++;
            $display("FAIL timeout_run: got %0d cycles %0d bad expected %0d 0", run_cyc, run_bad, WDOG);
        end
        n_checks++;
        if (state_o !== S_DONE || err_code !== 2'd2 || done !== 1'b1 || cpu_reset !== 1'b1 || imem_re !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_done: got state %0d err %0d done %b cpu_reset %b re %b expected 5 2 1 1 0",
                     state_o, err_code, done, cpu_reset, imem_re);
        end
        step();
        n_checks++;
        if (done !== 1'b0 || state_o !== S_DONE || err_code !== 2'd2) begin
            n_fail++;
            $display("FAIL timeout_pulse: got done %b state %0d err %0d expected 0 5 2", done, state_o, err_code);
        end
    endtask

    task automatic test_full_load();
        logic [2:0] st_load, st_end;
        logic [1:0] err_load;
        int         load_cyc, run_cyc, run_bad;
        for (int i = 0; i < DEPTH; i++) prog[i] = 8'($urandom);
        do_load(DEPTH, 1, 1'b0, st_load, err_load, load_cyc, st_end);
        n_checks++;
        if (st_load !== S_LOAD || err_load !== 2'd0 || load_cyc !== 2 * DEPTH - 1) begin
            n_fail++;
            $display("FAIL full_load: got state %0d err %0d cycles %0d expected 1 0 %0d",
                     st_load, err_load, load_cyc, 2 * DEPTH - 1);
        end
        n_checks++;
        if (obs_q.size() !== DEPTH || image_errors() !== 0) begin
            n_fail++;
            $display("FAIL full_image: got %0d writes %0d bad expected %0d writes 0 bad",
                     obs_q.size(), image_errors(), DEPTH);
        end
        n_checks++;
        if (st_cnt[S_FILL] !== 0 || st_cnt[S_BOOT] !== 1 || st_end !== S_RUN) begin
            n_fail++;
            $display("FAIL full_no_fill: got fill %0d boot %0d state %0d expected 0 1 4",
                     st_cnt[S_FILL], st_cnt[S_BOOT], st_end);
        end
        // Halt arrives on the very cycle the watchdog would expire.
        run_to_done(WDOG, run_cyc, run_bad);
        n_checks++;
        if (run_cyc !== WDOG || run_bad !== 0 || state_o !== S_DONE || err_code !== 2'd0 || done !== 1'b1) begin
            n_fail++;
            $display("FAIL halt_tie: got cycles %0d bad %0d state %0d err %0d done %b expected %0d 0 5 0 1",
                     run_cyc, run_bad, state_o, err_code, done, WDOG);
        end
    endtask

    task automatic test_random_loads();
        logic [2:0] st_load, st_end;
        logic [1:0] err_load;
        int         len, halt_cyc, load_cyc, run_cyc, run_bad;
        for (int it = 0; it < 3; it++) begin
            len = $urandom_range(1, DEPTH - 1);
            halt_cyc = $urandom_range(1, WDOG + 3);
            for (int i = 0; i < DEPTH; i++) prog[i] = 8'($urandom);
            do_load(len, 2, 1'b1, st_load, err_load, load_cyc, st_end);
            n_checks++;
            if (obs_q.size() !== DEPTH || image_errors() !== 0 || st_cnt[S_FILL] !== DEPTH - len) begin
                n_fail++;
                $display("FAIL rand_image_%0d: got %0d writes %0d bad fill %0d expected %0d 0 %0d",
                         len, obs_q.size(), image_errors(), st_cnt[S_FILL], DEPTH, DEPTH - len);
            end
            run_to_done(halt_cyc, run_cyc, run_bad);
            n_checks++;
            if (run_cyc !== exp_run_len(halt_cyc) || run_bad !== 0 || state_o !== S_DONE ||
                err_code !== exp_run_err(halt_cyc) || done !== 1'b1) begin
                n_fail++;
                $display("FAIL rand_run_h%0d: got cycles %0d bad %0d state %0d err %0d done %b expected %0d 0 5 %0d 1",
                         halt_cyc, run_cyc, run_bad, state_o, err_code, done,
                         exp_run_len(halt_cyc), exp_run_err(halt_cyc));
            end
        end
    endtask

    task automatic test_abort();
        int len;
        abort = 1'b1;
        step();
        abort = 1'b0;
        n_checks++;
        if (state_o !== S_IDLE || err_code !== 2'd3) begin
            n_fail++;
            $display("FAIL abort_in_done: got state %0d err %0d expected 0 3", state_o, err_code);
        end
        len = $urandom_range(5, 200);
        for (int i = 0; i < DEPTH; i++) prog[i] = 8'($urandom);
        clear_counts();
        start = 1'b1;
        load_len = (AW + 1)'(len);
        step();
        start = 1'b0;
        n_checks++;
        if (state_o !== S_LOAD || err_code !== 2'd0) begin
            n_fail++;
            $display("FAIL abort_restart: got state %0d err %0d expected 1 0", state_o, err_code);
        end
        in_valid = 1'b1;
        in_data = prog[0];
        step();
        in_data = prog[1];
        step();
        in_data = prog[2];
        abort = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b0 || imem_we !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_handshake: got ready %b we %b expected 0 0", in_ready, imem_we);
        end
        step();
        abort = 1'b0;
        in_valid = 1'b0;
        n_checks++;
        if (state_o !== S_IDLE || err_code !== 2'd3 || busy !== 1'b0 || obs_q.size() !== 2) begin
            n_fail++;
            $display("FAIL abort_load: got state %0d err %0d busy %b writes %0d expected 0 3 0 2",
                     state_o, err_code, busy, obs_q.size());
        end
    endtask

    task automatic test_async_reset_run();
        logic [2:0]  st_load, st_end;
        logic [1:0]  err_load;
        logic [26:0] v;
        int          load_cyc;
        prog[0] = 8'($urandom_range(1, 255));
        do_load(1, 0, 1'b0, st_load, err_load, load_cyc, st_end);
        n_checks++;
        if (obs_q.size() !== DEPTH || image_errors() !== 0 || st_cnt[S_FILL] !== DEPTH - 1) begin
            n_fail++;
            $display("FAIL min_len_image: got %0d writes %0d bad fill %0d expected %0d 0 %0d",
                     obs_q.size(), image_errors(), st_cnt[S_FILL], DEPTH, DEPTH - 1);
        end
        step();
        n_checks++;
        if (state_o !== S_RUN || cpu_reset !== 1'b0) begin
            n_fail++;
            $display("FAIL pre_reset_run: got state %0d cpu_reset %b expected 4 0", state_o, cpu_reset);
        end
        #2;
        reset = 1'b1;
        #1;
        v = {state_o, in_ready, imem_we, imem_re, imem_addr, imem_wdata, cpu_reset, busy, done, err_code};
        n_checks++;
        if (v !== RESET_VEC) begin
            n_fail++;
            $display("FAIL async_reset_run: got %h expected %h", v, RESET_VEC);
        end
        step();
        reset = 1'b0;
        step();
        n_checks++;
        if (state_o !== S_IDLE || cpu_reset !== 1'b1 || err_code !== 2'd0) begin
            n_fail++;
            $display("FAIL after_reset: got state %0d cpu_reset %b err %0d expected 0 1 0",
                     state_o, cpu_reset, err_code);
        end
        n_checks++;
        if (both_cnt !== 0) begin
            n_fail++;
            $display("FAIL we_re_exclusive: got %0d overlapping cycles expected 0", both_cnt);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_bad_len();
        test_short_load();
        test_full_load();
        test_random_loads();
        test_abort();
        test_async_reset_run();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
